inst_fetcher: RTL and testbench
===============================

Name: inst_fetcher

Overview:
- Front-end fetch stage; sits directly upstream of the memory controller's instruction-fetch port and feeds the decoder.
- Holds the fetch PC and issues one-instruction fetch requests (pc/start_fetch).
- Accepts the returned instruction and pushes {inst, pc} into a small FIFO that the decoder drains.
- Follows JAL statically; redirects on ROB clear-up.

Parameters:
- QUEUE_DEPTH_LOG, 3, log2 of instruction-queue entries (8 by default).
- RESET_PC, 32'h0, fetch PC after reset.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  reset; synchronous, active-high.
- rdy_in  input  1  ready; all state frozen when low.
- rob_clear_up  input  1  flush request from ROB.
- rob_redirect_pc  input  32  correct PC; valid while rob_clear_up is high.
- mem_pc  output  32  fetch address to the memory controller.
- mem_start_fetch  output  1  fetch request; level, held until serviced.
- mem_fetch_ready  input  1  one-cycle pulse, instruction valid.
- mem_inst  input  32  fetched instruction.
- mem_inst_addr  input  32  address of the fetched instruction.
- dec_valid  output  1  queue head valid.
- dec_inst  output  32  queue head instruction.
- dec_pc  output  32  queue head PC.
- dec_pop  input  1  decoder consumes the head this cycle.

Behaviour:
- Reset: fetch_pc=RESET_PC, queue empty, waiting=0. Outputs: mem_start_fetch=0, dec_valid=0, dec_inst=0, dec_pc=0, mem_pc=RESET_PC.
- Priority per cycle: rst_in > rob_clear_up > !rdy_in (hold) > normal.
- States:
  - IDLE: no request outstanding.
  - WAIT: request outstanding.
- mem_start_fetch = (state==WAIT). mem_pc = fetch_pc (registered; stable during WAIT).
- IDLE -> WAIT when count < 2^QUEUE_DEPTH_LOG. A request is issued only with free space, and only one is ever outstanding, so a response never overflows the queue.
- WAIT, mem_fetch_ready=1 and mem_inst_addr==fetch_pc:
  - Push {mem_inst, fetch_pc} into the queue.
  - Go to IDLE.
  - Next fetch_pc: if mem_inst[6:0]==7'b1101111 (JAL), fetch_pc + sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0}); else fetch_pc+4. 32-bit wrap, no overflow detection.
- WAIT, mem_fetch_ready=1 with an address mismatch: response dropped, remain in WAIT (stale response after a flush).
- mem_start_fetch is deasserted in the cycle after fetch_ready. It may re-assert the following cycle at the earliest, so the controller sees the new mem_pc before accepting the next request.
- Queue:
  - Circular buffer with head/tail pointers of QUEUE_DEPTH_LOG bits plus a count of QUEUE_DEPTH_LOG+1 bits.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - Pop when empty is ignored.
  - Pointers wrap modulo depth.
- dec_valid = count!=0. dec_inst/dec_pc show the head entry combinationally, and read 0 when empty.
- rob_clear_up (any state):
  - Queue emptied (count=0, head=tail=0).
  - fetch_pc <= rob_redirect_pc; state <= IDLE.
  - A mem_fetch_ready in the same cycle is discarded; a dec_pop in the same cycle is ignored.
  - The memory controller aborts its own outstanding fetch on the same signal; any late response is filtered by the address compare.
- rdy_in low: pointers, count, state and fetch_pc are held, and outputs keep their values. mem_fetch_ready/dec_pop are ignored while rdy_in is low.
- Throughput: at most one instruction per controller fetch; no bubble is added beyond the one-cycle request re-arm.

Decomposition:
- Shared constants (opcode JAL = 7'b1101111, instruction width 32) go in the common constants include with the other opcode macros.
- Natural sub-module: inst_queue, a parameterised FIFO (push/pop/flush, count, head data). The FSM, PC update and JAL immediate decode stay in inst_fetcher.

Test Plan:
- Reset, then release with the controller answering every fetch after 4 cycles with an ADDI (0x00100093) → requests at 0x0, 0x4, 0x8; queue entries carry pc 0x0/0x4/0x8; dec_valid rises 1 cycle after the first fetch_ready.
- Hold dec_pop=0 → after 8 pushes mem_start_fetch stays 0 and fetch_pc=0x20. One pop → the request re-issues at 0x20.
- JAL at pc 0x10 (inst 0x0100006F, imm=+16) → next mem_pc=0x20. JAL 0xFF1FF06F (imm=−16) at pc 0x10 → next mem_pc=0x0.
- rob_clear_up with rob_redirect_pc=0x100 while in WAIT, then a stale fetch_ready for addr 0x8 → dec_valid=0 next cycle, the stale response is dropped, and the next request is at 0x100.
- Simultaneous push and dec_pop with count=3 → count stays 3; head advances; a pointer wrap at entry 7→0 is exercised.
- rdy_in low for 5 cycles mid-WAIT with fetch_ready pulses ignored → no state change; the response is accepted once rdy_in is high again.

Source files
------------

// File: rtl/inst_fetcher_pkg.sv
//------------------------------------------------------------------------------
// Module  : inst_fetcher_pkg
// Brief   : Shared opcode constants, FSM encoding and JAL immediate decode.
// Rev     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package inst_fetcher_pkg;

    localparam int         INST_WIDTH = 32;
    localparam logic [6:0] OPCODE_JAL = 7'b1101111;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    // J-type immediate, sign-extended to the full PC width.
    function automatic logic [31:0] jal_imm(input logic [INST_WIDTH-1:0] inst);
        return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction

endpackage

`default_nettype wire

// File: rtl/inst_fetcher_queue.sv
//------------------------------------------------------------------------------
// Module  : inst_queue
// Brief   : Circular instruction FIFO with flush, enable and head readout.
// Rev     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module inst_queue #(
    parameter int DEPTH_LOG = 3,
    parameter int DATA_W    = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic                 flush_i,
    input  logic                 push_i,
    input  logic [DATA_W-1:0]    push_data_i,
    input  logic                 pop_i,
    output logic                 valid_o,
    output logic                 full_o,
    output logic [DATA_W-1:0]    head_data_o
);

    localparam int DEPTH = 1 << DEPTH_LOG;
    localparam logic [DEPTH_LOG:0] C_DEPTH = (DEPTH_LOG+1)'(DEPTH);

    logic [DATA_W-1:0]    mem_q [DEPTH];
    logic [DEPTH_LOG-1:0] head_q, head_d, tail_q, tail_d;
    logic [DEPTH_LOG:0]   count_q, count_d;
    logic                 do_push, do_pop;

    assign full_o      = (count_q == C_DEPTH);
    assign valid_o     = (count_q != '0);
    assign head_data_o = valid_o ? mem_q[head_q] : '0;

    assign do_push = en_i && !flush_i && push_i && !full_o;
    assign do_pop  = en_i && !flush_i && pop_i && valid_o;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (do_push) tail_d = tail_q + 1'b1;
            if (do_pop)  head_d = head_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible while counted.
    always_ff @(posedge clk_i) begin
        if (!rst_i && do_push) mem_q[tail_q] <= push_data_i;
    end

endmodule

`default_nettype wire

// File: rtl/inst_fetcher.sv
//------------------------------------------------------------------------------
// Module  : inst_fetcher
// Brief   : Fetch stage: PC/request FSM, static JAL follow, decoder FIFO.
// Rev     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module inst_fetcher
    import inst_fetcher_pkg::*;
#(
    parameter int          QUEUE_DEPTH_LOG = 3,
    parameter logic [31:0] RESET_PC        = 32'h0
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        rob_clear_up,
    input  logic [31:0] rob_redirect_pc,
    output logic [31:0] mem_pc,
    output logic        mem_start_fetch,
    input  logic        mem_fetch_ready,
    input  logic [31:0] mem_inst,
    input  logic [31:0] mem_inst_addr,
    output logic        dec_valid,
    output logic [31:0] dec_inst,
    output logic [31:0] dec_pc,
    input  logic        dec_pop
);

    logic [0:0]  state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic        push;
    logic        q_full;
    logic [63:0] q_head;

    assign mem_start_fetch = (state_q == ST_WAIT);
    assign mem_pc          = fetch_pc_q;
    assign dec_inst        = q_head[63:32];
    assign dec_pc          = q_head[31:0];

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        push       = 1'b0;
        if (rob_clear_up) begin
            state_d    = ST_IDLE;
            fetch_pc_d = rob_redirect_pc;
        end else if (rdy_in) begin
            case (state_q)
                ST_IDLE: if (!q_full) state_d = ST_WAIT;
                ST_WAIT: begin
                    // Mismatched addresses are stale responses from before a flush.
                    if (mem_fetch_ready && (mem_inst_addr == fetch_pc_q)) begin
                        push    = 1'b1;
                        state_d = ST_IDLE;
                        if (mem_inst[6:0] == OPCODE_JAL)
                            fetch_pc_d = fetch_pc_q + jal_imm(mem_inst);
                        else
                            fetch_pc_d = fetch_pc_q + 32'd4;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

    inst_queue #(
        .DEPTH_LOG (QUEUE_DEPTH_LOG),
        .DATA_W    (64)
    ) u_queue (
        .clk_i       (clk_in),
        .rst_i       (rst_in),
        .en_i        (rdy_in),
        .flush_i     (rob_clear_up),
        .push_i      (push),
        .push_data_i ({mem_inst, fetch_pc_q}),
        .pop_i       (dec_pop),
        .valid_o     (dec_valid),
        .full_o      (q_full),
        .head_data_o (q_head)
    );

endmodule

`default_nettype wire

// File: tb/tb_inst_fetcher.sv
//------------------------------------------------------------------------------
// Module  : tb_inst_fetcher
// Brief   : Directed bench with a scoreboard of expected {inst, pc} entries.
// Rev     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_inst_fetcher;

    localparam logic [31:0] ADDI  = 32'h0010_0093;
    localparam logic [31:0] JAL_P = 32'h0100_006F;
    localparam logic [31:0] JAL_N = 32'hFF1F_F06F;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, rob_clear_up, mem_fetch_ready, dec_pop;
    logic [31:0] rob_redirect_pc, mem_inst, mem_inst_addr;
    logic [31:0] mem_pc, dec_inst, dec_pc;
    logic        mem_start_fetch, dec_valid;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_pc;
    logic [63:0] sb[$];

    inst_fetcher #(.QUEUE_DEPTH_LOG(3), .RESET_PC(32'h0)) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .rdy_in          (rdy_in),
        .rob_clear_up    (rob_clear_up),
        .rob_redirect_pc (rob_redirect_pc),
        .mem_pc          (mem_pc),
        .mem_start_fetch (mem_start_fetch),
        .mem_fetch_ready (mem_fetch_ready),
        .mem_inst        (mem_inst),
        .mem_inst_addr   (mem_inst_addr),
        .dec_valid       (dec_valid),
        .dec_inst        (dec_inst),
        .dec_pc          (dec_pc),
        .dec_pop         (dec_pop)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic wait_req();
        int n = 0;
        while (mem_start_fetch !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("req_issued", {63'd0, mem_start_fetch}, 64'd1);
    endtask

    // Answer the outstanding fetch after lat cycles; optionally pop in the same cycle.
    task automatic serve(input logic [31:0] inst, input logic [31:0] next_pc,
                         input int lat, input logic with_pop);
        logic [63:0] h;
        wait_req();
        chk("req_pc", {32'd0, mem_pc}, {32'd0, exp_pc});
        repeat (lat - 1) tick();
        if (with_pop) begin
            h = (sb.size() != 0) ? sb.pop_front() : 64'd0;
            chk("head_inst", {32'd0, dec_inst}, {32'd0, h[63:32]});
            chk("head_pc", {32'd0, dec_pc}, {32'd0, h[31:0]});
            dec_pop = 1'b1;
        end
        mem_fetch_ready = 1'b1;
        mem_inst        = inst;
        mem_inst_addr   = exp_pc;
        tick();
        mem_fetch_ready = 1'b0;
        dec_pop         = 1'b0;
        sb.push_back({inst, exp_pc});
        exp_pc = next_pc;
        chk("req_drop", {63'd0, mem_start_fetch}, 64'd0);
    endtask

    task automatic pop_check();
        logic [63:0] h;
        h = (sb.size() != 0) ? sb.pop_front() : 64'd0;
        chk("pop_valid", {63'd0, dec_valid}, 64'd1);
        chk("pop_inst", {32'd0, dec_inst}, {32'd0, h[63:32]});
        chk("pop_pc", {32'd0, dec_pc}, {32'd0, h[31:0]});
        dec_pop = 1'b1;
        tick();
        dec_pop = 1'b0;
    endtask

    task automatic redirect(input logic [31:0] pc);
        rob_clear_up    = 1'b1;
        rob_redirect_pc = pc;
        tick();
        rob_clear_up = 1'b0;
        sb.delete();
        exp_pc = pc;
    endtask

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; rob_clear_up = 1'b0; rob_redirect_pc = '0;
        mem_fetch_ready = 1'b0; mem_inst = '0; mem_inst_addr = '0; dec_pop = 1'b0;
        exp_pc = 32'h0;
        repeat (3) tick();
        chk("rst_start", {63'd0, mem_start_fetch}, 64'd0);
        chk("rst_valid", {63'd0, dec_valid}, 64'd0);
        chk("rst_inst", {32'd0, dec_inst}, 64'd0);
        chk("rst_decpc", {32'd0, dec_pc}, 64'd0);
        chk("rst_mempc", {32'd0, mem_pc}, 64'd0);
        rst_in = 1'b0;

        // Basic fetch stream: 0x0, 0x4, 0x8
        serve(ADDI, 32'h4, 4, 1'b0);
        chk("valid_rise", {63'd0, dec_valid}, 64'd1);
        serve(ADDI, 32'h8, 4, 1'b0);
        serve(ADDI, 32'hC, 4, 1'b0);
        repeat (3) pop_check();

        // Fill the queue: after 8 pushes no further request.
        rst_in = 1'b1; tick(); rst_in = 1'b0;
        sb.delete(); exp_pc = 32'h0;
        for (int i = 0; i < 8; i++) serve(ADDI, exp_pc + 32'd4, 2, 1'b0);
        repeat (5) tick();
        chk("full_nostart", {63'd0, mem_start_fetch}, 64'd0);
        chk("full_pc", {32'd0, mem_pc}, 64'h20);
        pop_check();
        serve(ADDI, 32'h24, 3, 1'b0);

        // Drain to 3 entries, then push and pop together across the wrap.
        repeat (5) pop_check();
        serve(ADDI, 32'h28, 2, 1'b1);
        repeat (3) pop_check();
        chk("count3_empty", {63'd0, dec_valid}, 64'd0);

        // JAL forward and backward at pc 0x10.
        redirect(32'h10);
        serve(JAL_P, 32'h20, 2, 1'b0);
        serve(ADDI, 32'h24, 2, 1'b0);
        pop_check();
        pop_check();
        redirect(32'h10);
        serve(JAL_N, 32'h0, 2, 1'b0);
        serve(ADDI, 32'h4, 2, 1'b0);

        // Flush while waiting, then a stale response for 0x8.
        wait_req();
        redirect(32'h100);
        chk("flush_valid", {63'd0, dec_valid}, 64'd0);
        tick();
        mem_fetch_ready = 1'b1; mem_inst = ADDI; mem_inst_addr = 32'h8;
        tick();
        mem_fetch_ready = 1'b0;
        chk("stale_valid", {63'd0, dec_valid}, 64'd0);
        chk("stale_wait", {63'd0, mem_start_fetch}, 64'd1);
        serve(ADDI, 32'h104, 2, 1'b0);
        pop_check();

        // rdy_in low mid-WAIT: responses ignored, state frozen.
        wait_req();
        rdy_in = 1'b0;
        mem_inst = ADDI; mem_inst_addr = 32'h104;
        repeat (5) begin
            mem_fetch_ready = 1'b1;
            tick();
        end
        mem_fetch_ready = 1'b0;
        chk("hold_valid", {63'd0, dec_valid}, 64'd0);
        chk("hold_start", {63'd0, mem_start_fetch}, 64'd1);
        chk("hold_pc", {32'd0, mem_pc}, 64'h104);
        rdy_in = 1'b1;
        serve(ADDI, 32'h108, 1, 1'b0);
        pop_check();
        chk("final_empty", {63'd0, dec_valid}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
